// File: rtl/handshake_fifo_buffer.sv
// rtl/handshake_fifo_buffer.sv - elastic FIFO buffer stage for the handshake dataflow fabric
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    // Explicit wrap compare so non-power-of-two depths cycle through DEPTH slots.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready and valid derive only from the stored count, never from outs_ready,
    // and are forced low while reset is held so the stage looks inert.
    assign ins_ready  = rst && (count != FULL_CNT);
    assign outs_valid = rst && (count != '0);
    assign outs       = outs_valid ? mem[rd_ptr] : '0;

    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;

    // Token storage: written only on an accepted push, no reset needed since
    // slots are never presented until count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ins;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every held token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// tb/tb_handshake_fifo_buffer.sv - scoreboard bench for handshake_fifo_buffer at depths 4, 3 and 1
module tb_handshake_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ins_s  [3];
    logic [31:0] outs_s [3];
    logic        iv     [3];
    logic        ir     [3];
    logic        ov     [3];
    logic        orr    [3];
    logic        stuck  [3];
    logic [31:0] sb_q   [3][$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .ins(ins_s[0]), .ins_valid(iv[0]), .ins_ready(ir[0]),
        .outs(outs_s[0]), .outs_valid(ov[0]), .outs_ready(orr[0])
    );

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .ins(ins_s[1]), .ins_valid(iv[1]), .ins_ready(ir[1]),
        .outs(outs_s[1]), .outs_valid(ov[1]), .outs_ready(orr[1])
    );

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .ins(ins_s[2]), .ins_valid(iv[2]), .ins_ready(ir[2]),
        .outs(outs_s[2]), .outs_valid(ov[2]), .outs_ready(orr[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: record accepted inputs, pop and compare on every
    // output handshake, and police the output hold rule.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic        pv = 1'b0;
        logic [31:0] po = '0;
        always @(negedge clk) begin
            if (!rst) begin
                sb_q[g].delete();
                pv <= 1'b0;
            end else begin
                if (pv) begin
                    chk($sformatf("hold_valid[%0d]", g), 32'(ov[g]), 32'd1);
                    chk($sformatf("hold_data[%0d]", g), outs_s[g], po);
                end
                if (!ov[g]) begin
                    chk($sformatf("idle_outs_zero[%0d]", g), outs_s[g], 32'd0);
                end
                if (ov[g] && orr[g]) begin
                    if (sb_q[g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_token[%0d]: got %h expected none", g, outs_s[g]);
                    end else begin
                        chk($sformatf("order[%0d]", g), outs_s[g], sb_q[g].pop_front());
                    end
                end
                if (iv[g] && ir[g]) begin
                    sb_q[g].push_back(ins_s[g]);
                end
                pv <= ov[g] && !orr[g];
                po <= outs_s[g];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(input int g, input bit force_fill);
        if (!stuck[g]) begin
            iv[g]    = force_fill ? 1'b1 : 1'($urandom_range(0, 1));
            ins_s[g] = $urandom;
        end
        orr[g] = force_fill ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_random(input int cycles, input bit force_fill);
        for (int c = 0; c < cycles; c++) begin
            rand_step(0, force_fill);
            rand_step(2, force_fill);
            @(negedge clk);
            stuck[0] = iv[0] && !ir[0];
            stuck[2] = iv[2] && !ir[2];
            step();
        end
    endtask

    initial begin
        logic [31:0] fill_vals [4];
        fill_vals[0] = 32'h0D21;
        fill_vals[1] = 32'h1;
        fill_vals[2] = 32'h2;
        fill_vals[3] = 32'h3;
        for (int g = 0; g < 3; g++) begin
            ins_s[g] = '0;
            iv[g]    = 1'b0;
            orr[g]   = 1'b0;
            stuck[g] = 1'b0;
        end

        // Reset held with a token offered
        iv[0]    = 1'b1;
        ins_s[0] = 32'h0D21;
        orr[0]   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ins_ready", 32'(ir[0]), 32'd0);
        chk("rst_outs_valid", 32'(ov[0]), 32'd0);
        chk("rst_outs", outs_s[0], 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("release_ins_ready", 32'(ir[0]), 32'd1);

        // Single token, one-cycle latency, popped next edge
        step();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("single_valid", 32'(ov[0]), 32'd1);
        chk("single_data", outs_s[0], 32'h0D21);
        step();
        @(negedge clk);
        chk("single_empty_after", 32'(ov[0]), 32'd0);

        // Fill depth-4 instance with consumer stalled
        step();
        orr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[0]    = 1'b1;
            ins_s[0] = fill_vals[i];
            @(negedge clk);
            chk("fill_ready", 32'(ir[0]), 32'd1);
            if (i > 0) chk("fill_head", outs_s[0], 32'h0D21);
            step();
        end
        iv[0] = 1'b0;
        @(negedge clk);
        chk("full_ins_ready", 32'(ir[0]), 32'd0);
        chk("full_head", outs_s[0], 32'h0D21);

        // Full with simultaneous offer: first edge pops only
        step();
        orr[0]   = 1'b1;
        iv[0]    = 1'b1;
        ins_s[0] = 32'hAA;
        @(negedge clk);
        chk("fullpop_blocked", 32'(ir[0]), 32'd0);
        step();
        @(negedge clk);
        chk("fullpop_ready_next", 32'(ir[0]), 32'd1);
        step();
        iv[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_empty", 32'(ov[0]), 32'd0);
        chk("drain_sb_empty", 32'(sb_q[0].size()), 32'd0);

        // Depth-3 streaming: one token per cycle, pointers wrap
        step();
        orr[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv[1]    = 1'b1;
            ins_s[1] = 32'(i);
            @(negedge clk);
            chk("stream_ready", 32'(ir[1]), 32'd1);
            chk("stream_valid", 32'(ov[1]), (i > 0) ? 32'd1 : 32'd0);
            step();
        end
        iv[1] = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", 32'(ov[1]), 32'd1);
        chk("stream_last_data", outs_s[1], 32'd9);
        step();
        @(negedge clk);
        chk("stream_done", 32'(ov[1]), 32'd0);
        chk("stream_sb_empty", 32'(sb_q[1].size()), 32'd0);

        // Random stalls on depth 4 and depth 1 with a mid-run reset pulse
        step();
        run_random(500, 1'b0);
        run_random(5, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid_d4", 32'(ov[0]), 32'd1);
        chk("pre_rst_valid_d1", 32'(ov[2]), 32'd1);
        step();
        rst   = 1'b0;
        iv[0] = 1'b0;
        iv[2] = 1'b0;
        stuck[0] = 1'b0;
        stuck[2] = 1'b0;
        #1;
        chk("async_rst_valid_d4", 32'(ov[0]), 32'd0);
        chk("async_rst_valid_d1", 32'(ov[2]), 32'd0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid_d4", 32'(ov[0]), 32'd0);
        chk("post_rst_sb_d4", 32'(sb_q[0].size()), 32'd0);
        chk("post_rst_sb_d1", 32'(sb_q[2].size()), 32'd0);
        step();
        run_random(500, 1'b0);

        // Final drain
        for (int g = 0; g < 3; g++) begin
            if (!stuck[g]) iv[g] = 1'b0;
            orr[g] = 1'b1;
        end
        @(negedge clk);
        step();
        iv[0] = 1'b0;
        iv[2] = 1'b0;
        repeat (10) @(negedge clk);
        chk("final_empty_d4", 32'(ov[0]), 32'd0);
        chk("final_empty_d1", 32'(ov[2]), 32'd0);
        chk("final_sb_d4", 32'(sb_q[0].size()), 32'd0);
        chk("final_sb_d1", 32'(sb_q[2].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
